muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative multiply/divide sequencer beside the execution stage. Accepts MULT/MULTU/DIV/DIVU
//  with rs/rt operands, runs a 32-step shift-add / restoring-divide loop, and holds the pipeline
//  through a stall request until done. Owns the HI/LO architectural registers. Serves MTHI/MTLO
//  writes, and drives HI/LO read data for MFHI/MFLO.
// PARAMETERS
//  LEN     32  operand / HI / LO width
//  STEPS   32  iteration count; must equal LEN
// PORTS
//  clk           in   1    clock; all state changes on rising edge
//  rst           in   1    asynchronous, active-high reset
//  i_start       in   1    EX holds a valid mul/div op this cycle
//  i_md_op       in   2    00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  i_rs_reg      in   LEN  multiplicand / dividend
//  i_rt_reg      in   LEN  multiplier / divisor
//  i_flush       in   1    abort in-flight op (branch/jump squash)
//  is_mthi       in   1    write HI from i_rs_reg
//  is_mtlo       in   1    write LO from i_rs_reg
//  o_hi          out  LEN  HI register
//  o_lo          out  LEN  LO register
//  os_stall      out  1    freeze IF/ID/EX while an op is accepted or running
//  os_done       out  1    one-cycle pulse: HI/LO updated this edge
// BEHAVIOUR
//  Reset: state IDLE, o_hi=o_lo=0, os_done=0, step counter=0, os_stall=0 (os_stall is
//  combinational, so it reads 0 whenever state=IDLE and i_start=0).
//  FSM: IDLE -> RUN -> FIX -> IDLE.
//  - IDLE: on i_start, latch operands and op. Signed ops latch magnitudes plus sign flags.
//    Clear the accumulator and counter, then go to RUN.
//  - DIV/DIVU with rt==0: skip RUN and go to FIX with quotient=0xFFFFFFFF and remainder=rs
//    (raw rs, no sign fix).
//  - RUN: one step per cycle; the counter goes 0..STEPS-1 and the last step moves to FIX.
//    Mul: 2*LEN accumulator; add the multiplicand if the multiplier LSB is 1, then shift right.
//    Div: shift {rem,quot} left, trial-subtract the divisor, set the quot LSB if rem>=divisor.
//  - FIX: apply signs. MULT negates the 64-bit product if the signs differ. DIV negates the
//    quotient if the signs differ; the remainder takes the dividend sign.
//    Write HI=product[63:32]/remainder and LO=product[31:0]/quotient, pulse os_done, go IDLE.
//  - 0x80000000 / -1 (DIV) yields LO=0x80000000, HI=0; no trap.
//  Timing:
//  - os_stall = (IDLE & i_start) | (state!=IDLE). It is high from the acceptance cycle through
//    FIX, so a normal op stalls the pipeline for 34 cycles (accept + 32 RUN + FIX).
//  - HI/LO become visible the cycle after FIX. An MFHI/MFLO in ID during the stall reads the
//    new value.
//  Boundary cases:
//  - i_start while not IDLE: ignored (the pipeline is frozen, so it is the same instruction).
//  - i_flush in any state: return to IDLE next edge; HI/LO unchanged; no os_done.
//    i_flush has priority over i_start in the same cycle.
//  - is_mthi/is_mtlo: honoured only in IDLE with i_start=0. If both are set, both registers
//    are written. In all other states they are ignored.
//  - An FIX write and an MT write in the same cycle cannot occur (MT requires IDLE).
//  - Reset mid-operation: immediate return to reset values.
//  - No combinational path from i_rs_reg/i_rt_reg to any output.
// STRUCTURE
//  Shared package muldiv_pkg:
//  - MD_MULT/MD_MULTU/MD_DIV/MD_DIVU op codes
//  - FSM state encoding (IDLE=2'b00, RUN=2'b01, FIX=2'b10)
//  - STEP_CNT_W = $clog2(STEPS)
//  Sub-module muldiv_step: combinational single iteration, taking {acc, operand, op} and
//  returning the next acc. The sequencer keeps the FSM, counter, sign flags and HI/LO.
//  The execution stage's ALU control decodes funct into i_md_op and is_mthi/is_mtlo.
// TESTING
//  1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 34 stall cycles HI=0xFFFFFFFE, LO=0x00000001,
//     os_done for 1 cycle.
//  2. MULT -7*3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000*0x80000000 -> HI=0x40000000,
//     LO=0.
//  3. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
//     DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  4. DIVU 5/0 -> 2-cycle op, LO=0xFFFFFFFF, HI=5; MTHI 0x1234 in IDLE -> o_hi=0x1234 next
//     cycle; MTLO during RUN ignored.
//  5. i_flush at RUN step 10 -> IDLE next edge, os_stall low, HI/LO keep prior values,
//     no os_done; the next start runs a full 34 cycles.
//  6. rst asserted asynchronously mid-RUN -> outputs 0 without a clock edge; i_start held
//     across 2 ops gives exactly one accept per instruction.

Source files
------------

// File: rtl/muldiv_pkg.sv
package muldiv_pkg;

  localparam int unsigned MD_LEN     = 32;
  localparam int unsigned MD_STEPS   = 32;
  localparam int unsigned STEP_CNT_W = $clog2(MD_STEPS);

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
module muldiv_step #(
  parameter int unsigned LEN = 32
) (
  input  logic [2*LEN-1:0] acc,
  input  logic [LEN-1:0]   operand,
  input  logic             is_div,
  output logic [2*LEN-1:0] acc_next
);

  logic [LEN:0]   mul_sum;
  logic [2*LEN:0] div_shift;
  logic [LEN:0]   div_diff;

  // mul: acc = {hi, multiplier}; div: acc = {rem, quot}
  always_comb begin
    acc_next  = acc;
    mul_sum   = {1'b0, acc[2*LEN-1:LEN]};
    div_shift = {acc, 1'b0};
    div_diff  = div_shift[2*LEN:LEN] - {1'b0, operand};
    if (is_div) begin
      if (!div_diff[LEN]) begin
        acc_next = {div_diff[LEN-1:0], div_shift[LEN-1:1], 1'b1};
      end else begin
        acc_next = div_shift[2*LEN-1:0];
      end
    end else begin
      if (acc[0]) begin
        mul_sum = {1'b0, acc[2*LEN-1:LEN]} + {1'b0, operand};
      end
      acc_next = {mul_sum, acc[LEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned LEN   = MD_LEN,
  parameter int unsigned STEPS = MD_STEPS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [1:0]     i_md_op,
  input  logic [LEN-1:0] i_rs_reg,
  input  logic [LEN-1:0] i_rt_reg,
  input  logic           i_flush,
  input  logic           is_mthi,
  input  logic           is_mtlo,
  output logic [LEN-1:0] o_hi,
  output logic [LEN-1:0] o_lo,
  output logic           os_stall,
  output logic           os_done
);

  localparam logic [STEP_CNT_W-1:0] CNT_LAST = STEP_CNT_W'(STEPS - 1);

  md_state_e             state, state_nxt;
  logic [STEP_CNT_W-1:0] cnt;
  logic [2*LEN-1:0]      acc, acc_step, prod_fix;
  logic [LEN-1:0]        operand, rs_mag, rt_mag, fix_hi, fix_lo;
  logic                  op_div, neg_q, neg_r;
  logic                  in_signed, in_div, div_zero, accept, fix_wr;

  always_comb begin
    in_signed = 1'b0;
    in_div    = 1'b0;
    unique case (i_md_op)
      MD_MULT:  begin in_signed = 1'b1; in_div = 1'b0; end
      MD_MULTU: begin in_signed = 1'b0; in_div = 1'b0; end
      MD_DIV:   begin in_signed = 1'b1; in_div = 1'b1; end
      MD_DIVU:  begin in_signed = 1'b0; in_div = 1'b1; end
    endcase
    div_zero = in_div && (i_rt_reg == '0);
    rs_mag   = (in_signed && i_rs_reg[LEN-1]) ? -i_rs_reg : i_rs_reg;
    rt_mag   = (in_signed && i_rt_reg[LEN-1]) ? -i_rt_reg : i_rt_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fix_wr    = 1'b0;
    if (i_flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (i_start) begin
          accept    = 1'b1;
          state_nxt = div_zero ? FIX : RUN;
        end
        RUN: if (cnt == CNT_LAST) state_nxt = FIX;
        FIX: begin
          fix_wr    = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign os_stall = ((state == IDLE) && i_start) || (state != IDLE);

  muldiv_step #(.LEN(LEN)) u_step (
    .acc      (acc),
    .operand  (operand),
    .is_div   (op_div),
    .acc_next (acc_step)
  );

  // sign flags are cleared for divide-by-zero so FIX passes the raw result through
  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    fix_hi   = prod_fix[2*LEN-1:LEN];
    fix_lo   = prod_fix[LEN-1:0];
    if (op_div) begin
      fix_hi = neg_r ? -acc[2*LEN-1:LEN] : acc[2*LEN-1:LEN];
      fix_lo = neg_q ? -acc[LEN-1:0]     : acc[LEN-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      operand <= '0;
      op_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      o_hi    <= '0;
      o_lo    <= '0;
      os_done <= 1'b0;
    end else begin
      os_done <= 1'b0;
      if (accept) begin
        cnt    <= '0;
        op_div <= in_div;
        if (div_zero) begin
          acc     <= {i_rs_reg, {LEN{1'b1}}};
          operand <= '0;
          neg_q   <= 1'b0;
          neg_r   <= 1'b0;
        end else if (in_div) begin
          acc     <= {{LEN{1'b0}}, rs_mag};
          operand <= rt_mag;
          neg_q   <= in_signed && (i_rs_reg[LEN-1] ^ i_rt_reg[LEN-1]);
          neg_r   <= in_signed && i_rs_reg[LEN-1];
        end else begin
          acc     <= {{LEN{1'b0}}, rt_mag};
          operand <= rs_mag;
          neg_q   <= in_signed && (i_rs_reg[LEN-1] ^ i_rt_reg[LEN-1]);
          neg_r   <= 1'b0;
        end
      end else if ((state == RUN) && !i_flush) begin
        acc <= acc_step;
        cnt <= cnt + 1'b1;
      end

      if (fix_wr) begin
        o_hi    <= fix_hi;
        o_lo    <= fix_lo;
        os_done <= 1'b1;
      end else if ((state == IDLE) && !i_start) begin
        if (is_mthi) o_hi <= i_rs_reg;
        if (is_mtlo) o_lo <= i_rs_reg;
      end
    end
  end

endmodule
